mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the fetch stage, the memory-access stage and the unified memory port.
- Data has priority. A streak limit bounds fetch starvation.
- Ownership is locked for the duration of a stalled transaction, so the memory sees stable addr/wdata/wstrb.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- MAX_D_STREAK, 4, max consecutive completed D transactions granted while I is pending (legal range 1..15)
- CNT_W, 32, width of the stall performance counter

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_valid  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  fetch transaction completes this cycle
- i_rdata  out  DATA_W  fetch read data, valid when i_ready
- d_valid  in  1  load/store request
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  byte strobes; 0 means load
- d_ready  out  1  load/store completes this cycle
- d_rdata  out  DATA_W  load data, valid when d_ready
- mem_valid  out  1  downstream request
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream store data
- mem_wstrb  out  DATA_W/8  downstream strobes
- mem_ready  in  1  downstream completion (same-cycle rdata)
- mem_rdata  in  DATA_W  downstream read data
- owner  out  2  one-hot current selection: [0]=I, [1]=D, 00=none
- i_stall_cnt  out  CNT_W  cycles with i_valid=1 and i_ready=0

Behaviour:
- Transaction model: a transfer completes in a cycle with mem_valid && mem_ready. Arbitration and muxing are combinational, so there are zero added cycles of latency.
- FSM has three states: IDLE, HOLD_I, HOLD_D.
- IDLE selection:
  - Select D if d_valid && (!i_valid || streak < MAX_D_STREAK).
  - Otherwise select I if i_valid.
  - Otherwise select none.
- HOLD_x: selection is forced to x regardless of the other requester's valid.
- Muxing when x is selected:
  - mem_valid = x_valid; mem_addr = x_addr.
  - mem_wdata/mem_wstrb = D values when D is selected. When I is selected, wdata = 0 and wstrb = 0.
- Muxing when none is selected: mem_valid=0 and addr/wdata/wstrb = 0.
- Ready routing: only the selected requester sees x_ready = mem_ready. The other requester's ready is 0.
- rdata routing: i_rdata and d_rdata both equal mem_rdata (broadcast). Requesters qualify it with their own ready.
- Transitions:
  - Selected x with x_valid && !mem_ready: next state HOLD_x.
  - Selected x with mem_ready: next state IDLE.
  - In HOLD_x, if x_valid drops: the request is abandoned, mem_valid=0 that cycle, next state IDLE. The fetch stage legitimately deasserts valid while waiting.
- Streak counter (4 bits), updated at a completed D transaction:
  - i_valid=1 that cycle: streak = min(streak+1, MAX_D_STREAK).
  - i_valid=0: streak = 0.
- Streak counter, other updates:
  - Completed I transaction: streak = 0.
  - Otherwise unchanged.
- When streak == MAX_D_STREAK and i_valid=1 in IDLE, I wins even if d_valid=1.
- i_stall_cnt increments every cycle with i_valid && !i_ready. It wraps modulo 2^CNT_W and never saturates.
- owner reflects the combinational selection above, not the registered state.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, streak=0, i_stall_cnt=0.
  - While rst_n=0, outputs are forced to 0: mem_valid, i_ready, d_ready, owner. An in-flight HOLD is discarded.
- Simultaneous events:
  - Both requesters valid in IDLE: the priority rule above applies.
  - A new request from the non-owner during HOLD waits; no preemption.

Test Plan:
- Solo fetch, mem_ready=1 each cycle, i_addr 0x0,0x4,0x8 → mem_addr follows. i_ready=1 each cycle. owner=01. d_ready=0. i_stall_cnt=0.
- Store 0x100, wdata 0xDEADBEEF, wstrb 0xF, with mem_ready low 3 cycles. i_valid rises in cycle 2 → owner stays 10 through completion. I is granted the cycle after d_ready. i_stall_cnt=3.
- Both valid continuously, mem_ready=1, MAX_D_STREAK=4 → grant sequence D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each I.
- Fetch 0x40 stalled (mem_ready=0) for 2 cycles, then i_valid drops → mem_valid=0 next cycle, state IDLE. A pending D is granted the following cycle.
- Reset asserted during HOLD_D → next cycle mem_valid=0, owner=00, i_stall_cnt=0, streak=0. After release, I alone is granted immediately.
- Preload i_stall_cnt to 2^CNT_W−1 via forced stall cycles (CNT_W=4 build) → the 16th stall cycle wraps it to 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (I) and load/store (D).
// Data wins by default; a bounded D streak guarantees fetch progress.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int CNT_W        = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_ready,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_valid,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_ready,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_valid,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [1:0]          owner,
   output logic [CNT_W-1:0]    i_stall_cnt
);

   localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

   typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_e;

   state_e           state_q, state_d;
   logic [3:0]       streak_q, streak_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             sel_i, sel_d;
   logic             i_done, d_done;

   always_comb begin
      sel_i = 1'b0;
      sel_d = 1'b0;
      unique case (state_q)
         HOLD_I: sel_i = 1'b1;
         HOLD_D: sel_d = 1'b1;
         default: begin
            sel_d = d_valid && (!i_valid || streak_q < MAX_S);
            sel_i = !sel_d && i_valid;
         end
      endcase
      // reset masks selection so every handshake output reads zero
      if (!rst_n) begin
         sel_i = 1'b0;
         sel_d = 1'b0;
      end
   end

   assign mem_valid   = (sel_i & i_valid) | (sel_d & d_valid);
   assign mem_addr    = sel_d ? d_addr : (sel_i ? i_addr : '0);
   assign mem_wdata   = sel_d ? d_wdata : '0;
   assign mem_wstrb   = sel_d ? d_wstrb : '0;
   assign i_ready     = sel_i & mem_ready;
   assign d_ready     = sel_d & mem_ready;
   assign i_rdata     = mem_rdata;
   assign d_rdata     = mem_rdata;
   assign owner       = {sel_d, sel_i};
   assign i_stall_cnt = stall_q;

   assign i_done = sel_i & i_valid & mem_ready;
   assign d_done = sel_d & d_valid & mem_ready;

   always_comb begin
      state_d = IDLE;
      if (sel_i && i_valid && !mem_ready) begin
         state_d = HOLD_I;
      end else if (sel_d && d_valid && !mem_ready) begin
         state_d = HOLD_D;
      end
      streak_d = streak_q;
      if (d_done) begin
         if (!i_valid) begin
            streak_d = '0;
         end else if (streak_q >= MAX_S) begin
            streak_d = MAX_S;
         end else begin
            streak_d = streak_q + 4'd1;
         end
      end else if (i_done) begin
         streak_d = '0;
      end
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, (i_valid & ~i_ready)};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         streak_q <= '0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         stall_q  <= stall_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a transfer scoreboard.
// Expected completions are queued by stimulus and popped by a negedge monitor.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW/8;
   localparam int CW = 4;
   localparam logic [31:0] KEY = 32'hA5A5_5A5A;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_valid;
   logic [AW-1:0] i_addr;
   logic          i_ready;
   logic [DW-1:0] i_rdata;
   logic          d_valid;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [SW-1:0] d_wstrb;
   logic          d_ready;
   logic [DW-1:0] d_rdata;
   logic          mem_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [SW-1:0] mem_wstrb;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   logic [1:0]    owner;
   logic [CW-1:0] i_stall_cnt;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid), .i_addr(i_addr),
      .i_ready(i_ready), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .owner(owner), .i_stall_cnt(i_stall_cnt)
   );

   always #5 clk = ~clk;

   // memory model: read data is a keyed function of the address
   assign mem_rdata = mem_addr ^ KEY;

   typedef struct {
      logic        is_d;
      logic [31:0] addr;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endfunction

   function automatic void push(logic is_d, logic [31:0] addr);
      exp_t e;
      e.is_d = is_d;
      e.addr = addr;
      q.push_back(e);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (i_ready || d_ready) begin
         if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_ready: got i=%b d=%b want none",
                     i_ready, d_ready);
         end else begin
            e = q.pop_front();
            chk("xfer_ready", {30'd0, d_ready, i_ready},
                e.is_d ? 32'd2 : 32'd1);
            chk("xfer_owner", {30'd0, owner}, e.is_d ? 32'd2 : 32'd1);
            chk("xfer_addr", mem_addr, e.addr);
            chk("xfer_rdata", e.is_d ? d_rdata : i_rdata, e.addr ^ KEY);
         end
      end
   end

   task automatic idle();
      i_valid   = 1'b0;
      i_addr    = '0;
      d_valid   = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      d_wstrb   = '0;
      mem_ready = 1'b0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nxt();
      idle();
      rst_n = 1'b0;
      nxt();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      do_reset();
      @(negedge clk);
      chk("rst_stall", {28'd0, i_stall_cnt}, 32'd0);
      chk("rst_owner", {30'd0, owner}, 32'd0);
      chk("rst_mvalid", {31'd0, mem_valid}, 32'd0);

      // solo fetch stream
      for (int k = 0; k < 3; k++) begin
         nxt();
         i_valid = 1'b1;
         i_addr = 32'(4 * k);
         mem_ready = 1'b1;
         push(1'b0, 32'(4 * k));
         @(negedge clk);
         chk("s1_owner", {30'd0, owner}, 32'd1);
         chk("s1_dready", {31'd0, d_ready}, 32'd0);
      end
      nxt();
      idle();
      @(negedge clk);
      chk("s1_stall", {28'd0, i_stall_cnt}, 32'd0);

      // stalled store; fetch arrives mid-stall and waits
      do_reset();
      nxt();
      d_valid = 1'b1;
      d_addr = 32'h100;
      d_wdata = 32'hDEAD_BEEF;
      d_wstrb = 4'hF;
      i_addr = 32'h200;
      @(negedge clk);
      chk("s2_owner1", {30'd0, owner}, 32'd2);
      chk("s2_mvalid", {31'd0, mem_valid}, 32'd1);
      chk("s2_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("s2_wstrb", {28'd0, mem_wstrb}, 32'hF);
      for (int k = 0; k < 2; k++) begin
         nxt();
         i_valid = 1'b1;
         @(negedge clk);
         chk("s2_owner_hold", {30'd0, owner}, 32'd2);
         chk("s2_hold_addr", mem_addr, 32'h100);
      end
      nxt();
      mem_ready = 1'b1;
      push(1'b1, 32'h100);
      nxt();
      d_valid = 1'b0;
      push(1'b0, 32'h200);
      @(negedge clk);
      chk("s2_stall", {28'd0, i_stall_cnt}, 32'd3);
      chk("s2_i_wdata", mem_wdata, 32'd0);
      chk("s2_i_wstrb", {28'd0, mem_wstrb}, 32'd0);
      nxt();
      idle();

      // both requesters continuously valid: streak limit forces I in
      do_reset();
      for (int k = 0; k < 10; k++) begin
         nxt();
         i_valid = 1'b1;
         i_addr = 32'h300;
         d_valid = 1'b1;
         d_addr = 32'h400;
         mem_ready = 1'b1;
         if (k == 4 || k == 9) push(1'b0, 32'h300);
         else push(1'b1, 32'h400);
      end
      nxt();
      idle();

      // stalled fetch abandoned; pending D follows
      do_reset();
      nxt();
      i_valid = 1'b1;
      i_addr = 32'h40;
      @(negedge clk);
      chk("s4_owner1", {30'd0, owner}, 32'd1);
      nxt();
      d_valid = 1'b1;
      d_addr = 32'h500;
      @(negedge clk);
      chk("s4_owner2", {30'd0, owner}, 32'd1);
      chk("s4_addr2", mem_addr, 32'h40);
      nxt();
      i_valid = 1'b0;
      @(negedge clk);
      chk("s4_abandon", {31'd0, mem_valid}, 32'd0);
      nxt();
      mem_ready = 1'b1;
      push(1'b1, 32'h500);
      nxt();
      idle();

      // reset during HOLD_D
      do_reset();
      nxt();
      d_valid = 1'b1;
      d_addr = 32'h600;
      nxt();
      i_valid = 1'b1;
      i_addr = 32'h700;
      nxt();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("s5_rst_mvalid", {31'd0, mem_valid}, 32'd0);
      chk("s5_rst_owner", {30'd0, owner}, 32'd0);
      chk("s5_rst_dready", {31'd0, d_ready}, 32'd0);
      nxt();
      @(negedge clk);
      chk("s5_rst_stall", {28'd0, i_stall_cnt}, 32'd0);
      nxt();
      rst_n = 1'b1;
      d_valid = 1'b0;
      push(1'b0, 32'h700);
      @(negedge clk);
      chk("s5_owner", {30'd0, owner}, 32'd1);
      nxt();
      idle();

      // stall counter wraps at 2^CW
      do_reset();
      for (int k = 0; k < 16; k++) begin
         nxt();
         i_valid = 1'b1;
         i_addr = 32'h800;
      end
      @(negedge clk);
      chk("s6_stall_max", {28'd0, i_stall_cnt}, 32'd15);
      nxt();
      mem_ready = 1'b1;
      push(1'b0, 32'h800);
      @(negedge clk);
      chk("s6_stall_wrap", {28'd0, i_stall_cnt}, 32'd0);
      nxt();
      idle();

      repeat (3) nxt();
      chk("sb_empty", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
